// File: rtl/lynx_pkg.sv
// Shared PS/2 receiver definitions: frame state encoding, prefix byte codes
// and the odd-parity helper.
package lynx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    // Odd parity holds when data plus parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_filter.sv
// PS/2 line conditioning: 2-FF synchronisers on both lines and a ce-rate
// glitch filter on the clock line that emits a one-clock fall strobe.
module ps2_filter #(
    parameter int FILTER = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic ce,
    input  logic ps2clk,
    input  logic ps2dat,
    output logic clk_filt,
    output logic dat_sync,
    output logic fall
);

    localparam int CW = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(FILTER - 1);

    logic [1:0]    clk_sync_q, clk_sync_d;
    logic [1:0]    dat_sync_q, dat_sync_d;
    logic          filt_q, filt_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Down-counter reloads whenever the synchronised level agrees with the
    // filtered one, so only an unbroken run of FILTER opposite samples flips it.
    always_comb begin
        clk_sync_d = {clk_sync_q[0], ps2clk};
        dat_sync_d = {dat_sync_q[0], ps2dat};
        filt_d     = filt_q;
        cnt_d      = cnt_q;
        fall       = 1'b0;
        if (ce) begin
            if (clk_sync_q[1] == filt_q) begin
                cnt_d = CNT_LOAD;
            end else if (cnt_q == '0) begin
                filt_d = clk_sync_q[1];
                cnt_d  = CNT_LOAD;
                fall   = ~clk_sync_q[1];
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            filt_q     <= 1'b1;
            cnt_q      <= CNT_LOAD;
        end else begin
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            filt_q     <= filt_d;
            cnt_q      <= cnt_d;
        end
    end

    assign clk_filt = filt_q;
    assign dat_sync = dat_sync_q[1];

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 keyboard frame receiver with E0/F0 prefix folding.
// Define PS2_TIMEOUT_EN to abort frames that stall for TIMEOUT ce ticks.
//
//   state     | meaning
//   ST_IDLE   | waiting for a start bit (sample of 0)
//   ST_DATA   | shifting in 8 data bits, LSB first
//   ST_PARITY | capturing the odd parity bit
//   ST_STOP   | checking stop bit and parity, then decoding the byte
module ps2_receiver
    import lynx_pkg::*;
#(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 6000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic       ps2clk,
    input  logic       ps2dat,
    output logic       valid,
    output logic [7:0] code,
    output logic       released,
    output logic       extended,
    output logic       error
);

    if (FILTER < 1 || TIMEOUT < 1) begin : g_param_check
        $error("ps2_receiver: FILTER and TIMEOUT must be at least 1");
    end

    logic       fall;
    logic       dat;
    logic       clk_level_unused;

    ps2_state_e state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       par_q, par_d;
    logic       valid_q, valid_d;
    logic [7:0] code_q, code_d;
    logic       released_q, released_d;
    logic       extended_q, extended_d;
    logic       error_q, error_d;
    logic       ext_pend_q, ext_pend_d;
    logic       brk_pend_q, brk_pend_d;

`ifdef PS2_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(1);
    logic [TW-1:0] tmo_q, tmo_d;
`endif

    ps2_filter #(.FILTER(FILTER)) u_filter (
        .clock    (clock),
        .reset    (reset),
        .ce       (ce),
        .ps2clk   (ps2clk),
        .ps2dat   (ps2dat),
        .clk_filt (clk_level_unused),
        .dat_sync (dat),
        .fall     (fall)
    );

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        valid_d    = 1'b0;
        code_d     = code_q;
        released_d = released_q;
        extended_d = extended_q;
        error_d    = 1'b0;
        ext_pend_d = ext_pend_q;
        brk_pend_d = brk_pend_q;
`ifdef PS2_TIMEOUT_EN
        tmo_d      = tmo_q;
`endif
        if (fall) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!dat) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                ST_DATA: begin
                    shift_d   = {dat, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                end
                ST_PARITY: begin
                    par_d   = dat;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (dat && odd_parity_ok(shift_q, par_q)) begin
                        if (shift_q == PS2_EXT) begin
                            ext_pend_d = 1'b1;
                        end else if (shift_q == PS2_BRK) begin
                            brk_pend_d = 1'b1;
                        end else begin
                            valid_d    = 1'b1;
                            code_d     = shift_q;
                            released_d = brk_pend_q;
                            extended_d = ext_pend_q;
                            ext_pend_d = 1'b0;
                            brk_pend_d = 1'b0;
                        end
                    end else begin
                        error_d    = 1'b1;
                        ext_pend_d = 1'b0;
                        brk_pend_d = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
`ifdef PS2_TIMEOUT_EN
        // Watchdog reloads on every sampled edge and while idle.
        if (state_q == ST_IDLE || fall) begin
            tmo_d = TMO_LOAD;
        end else if (ce) begin
            if (tmo_q == TMO_LAST) begin
                tmo_d      = TMO_LOAD;
                state_d    = ST_IDLE;
                error_d    = 1'b1;
                ext_pend_d = 1'b0;
                brk_pend_d = 1'b0;
            end else begin
                tmo_d = tmo_q - 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'd0;
            par_q      <= 1'b0;
            valid_q    <= 1'b0;
            code_q     <= 8'd0;
            released_q <= 1'b0;
            extended_q <= 1'b0;
            error_q    <= 1'b0;
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
`ifdef PS2_TIMEOUT_EN
            tmo_q      <= TMO_LOAD;
`endif
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            valid_q    <= valid_d;
            code_q     <= code_d;
            released_q <= released_d;
            extended_q <= extended_d;
            error_q    <= error_d;
            ext_pend_q <= ext_pend_d;
            brk_pend_q <= brk_pend_d;
`ifdef PS2_TIMEOUT_EN
            tmo_q      <= tmo_d;
`endif
        end
    end

    assign valid    = valid_q;
    assign code     = code_q;
    assign released = released_q;
    assign extended = extended_q;
    assign error    = error_q;

endmodule

// File: tb/tb_ps2_receiver.sv
// Scoreboard bench for ps2_receiver: frames are bit-banged on the raw lines,
// a keyboard-level model predicts decoded keys and errors.
module tb_ps2_receiver;
    import lynx_pkg::*;

    localparam int FILTER  = 8;
    localparam int TIMEOUT = 6000;

    logic       clock  = 1'b0;
    logic       reset  = 1'b0;
    logic       ce     = 1'b0;
    logic       ps2clk = 1'b1;
    logic       ps2dat = 1'b1;
    logic       valid;
    logic [7:0] code;
    logic       released;
    logic       extended;
    logic       error;

    ps2_receiver #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
        .clock    (clock),
        .reset    (reset),
        .ce       (ce),
        .ps2clk   (ps2clk),
        .ps2dat   (ps2dat),
        .valid    (valid),
        .code     (code),
        .released (released),
        .extended (extended),
        .error    (error)
    );

    always #5 clock = ~clock;

    int ce_div = 0;
    always @(posedge clock) begin
        ce_div <= (ce_div == 3) ? 0 : ce_div + 1;
        ce     <= (ce_div == 3);
    end

    typedef struct packed {
        logic [7:0] code;
        logic       rel;
        logic       ext;
    } exp_t;

    exp_t exp_q[$];
    int   err_exp = 0;
    int   checks  = 0;
    int   errors  = 0;
    bit   m_ext   = 0;
    bit   m_brk   = 0;
    exp_t model_last = '0;
    exp_t mon_e;

    // Keyboard-level model: prefixes accumulate, a bad frame drops them.
    function automatic void model_frame(input logic [7:0] b, input bit good);
        if (!good) begin
            err_exp++;
            m_ext = 0;
            m_brk = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            model_last = '{code: b, rel: m_brk, ext: m_ext};
            exp_q.push_back(model_last);
            m_ext = 0;
            m_brk = 0;
        end
    endfunction

    always @(negedge clock) begin
        if (valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got code=%h rel=%b ext=%b, expected no valid",
                         code, released, extended);
            end else begin
                mon_e = exp_q.pop_front();
                if ({code, released, extended} !== mon_e) begin
                    errors++;
                    $display("FAIL decode: got code=%h rel=%b ext=%b, expected code=%h rel=%b ext=%b",
                             code, released, extended, mon_e.code, mon_e.rel, mon_e.ext);
                end
            end
        end
        if (error) begin
            checks++;
            if (err_exp == 0) begin
                errors++;
                $display("FAIL unexpected_error: got error=1, expected 0");
            end else begin
                err_exp--;
            end
        end
    end

    task automatic wait_ce(input int n);
        for (int i = 0; i < n; i++) begin
            do @(negedge clock); while (!ce);
        end
    endtask

    task automatic send_bit(input logic v);
        ps2dat = v;
        wait_ce(3);
        ps2clk = 1'b0;
        wait_ce(10);
        ps2clk = 1'b1;
        wait_ce(7);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit par_ok, input bit stop);
        logic p;
        p = par_ok ? ~^b : ^b;
        model_frame(b, par_ok && stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(p);
        send_bit(stop);
        ps2dat = 1'b1;
        wait_ce(4);
    endtask

    task automatic check_hold(input string name);
        checks++;
        if ({code, released, extended} !== model_last) begin
            errors++;
            $display("FAIL %s: got code=%h rel=%b ext=%b, expected code=%h rel=%b ext=%b",
                     name, code, released, extended, model_last.code, model_last.rel, model_last.ext);
        end
    endtask

    task automatic check_drain(input string name);
        checks++;
        if (exp_q.size() != 0 || err_exp != 0) begin
            errors++;
            $display("FAIL %s: got pending valids=%0d errors=%0d, expected 0 and 0",
                     name, exp_q.size(), err_exp);
        end
    endtask

    task automatic check_state(input string name, input ps2_state_e want);
        checks++;
        if (dut.state_q !== want) begin
            errors++;
            $display("FAIL %s: got state=%0d, expected %0d", name, dut.state_q, want);
        end
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        ps2clk = 1'b1;
        ps2dat = 1'b1;
        m_ext  = 0;
        m_brk  = 0;
        model_last = '0;
        repeat (5) @(negedge clock);
        checks++;
        if ({valid, code, released, extended, error} !== 12'd0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b code=%h rel=%b ext=%b err=%b, expected all 0",
                     valid, code, released, extended, error);
        end
        check_state("reset_state", ST_IDLE);
        reset = 1'b1;
        wait_ce(4);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int         r;
        int         n;
        bit         seen;

        do_reset();

        send_frame(8'h1C, 1, 1);
        check_hold("plain_1c");
        check_drain("plain_1c_drain");

        send_frame(8'hF0, 1, 1);
        send_frame(8'h1C, 1, 1);
        check_hold("break_1c");
        check_drain("break_1c_drain");

        send_frame(8'hE0, 1, 1);
        send_frame(8'hF0, 1, 1);
        send_frame(8'h75, 1, 1);
        check_hold("ext_break_75");
        send_frame(8'h75, 1, 1);
        check_hold("flags_cleared_75");
        check_drain("ext_break_drain");

        send_frame(8'h1C, 0, 1);
        check_hold("bad_parity_hold");
        send_frame(8'h1C, 1, 1);
        check_hold("after_bad_parity");
        check_drain("bad_parity_drain");

        send_frame(8'hF0, 1, 1);
        send_frame(8'h1C, 1, 0);
        send_frame(8'h1C, 1, 1);
        check_hold("bad_stop_clears_flags");
        check_drain("bad_stop_drain");

        send_frame(8'hE0, 1, 1);
        send_frame(8'hE0, 1, 1);
        send_frame(8'hF0, 1, 1);
        send_frame(8'hE0, 1, 1);
        send_frame(8'h5A, 1, 1);
        check_hold("repeated_prefixes");
        check_drain("prefix_drain");

        // Low pulse one ce tick shorter than the filter, data held low.
        ps2dat = 1'b0;
        ps2clk = 1'b0;
        wait_ce(FILTER - 1);
        ps2clk = 1'b1;
        ps2dat = 1'b1;
        wait_ce(12);
        check_state("glitch_state", ST_IDLE);
        check_drain("glitch_drain");
        send_frame(8'h29, 1, 1);
        check_hold("after_glitch");

        for (int k = 0; k < 18; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      b = 8'hE0;
            else if (r == 1) b = 8'hF0;
            else             b = 8'($urandom_range(0, 255));
            send_frame(b, $urandom_range(0, 9) != 0, $urandom_range(0, 19) != 0);
            check_hold("random_hold");
        end
        check_drain("random_drain");

        // Stall after the start bit and four data bits.
`ifdef PS2_TIMEOUT_EN
        err_exp++;
        m_ext = 0;
        m_brk = 0;
`endif
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        ps2dat = 1'b1;
        wait_ce(3);
        ps2clk = 1'b0;
        n    = 0;
        seen = 0;
        while (n < FILTER + TIMEOUT + 20 && !seen) begin
            @(negedge clock);
            if (error) seen = 1;
            else if (ce) n++;
            if (n >= 10) ps2clk = 1'b1;
        end
`ifdef PS2_TIMEOUT_EN
        checks++;
        if (!seen || n < FILTER + TIMEOUT - 2 || n > FILTER + TIMEOUT + 2) begin
            errors++;
            $display("FAIL timeout_latency: got error=%b after %0d ce ticks, expected error near %0d",
                     seen, n, FILTER + TIMEOUT);
        end
        wait_ce(2);
        check_state("timeout_idle", ST_IDLE);
`else
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL no_timeout: got error after %0d ce ticks, expected none", n);
        end
        check_state("stalled_waits", ST_DATA);
`endif
        check_drain("stall_drain");

        do_reset();
        send_frame(8'h1C, 1, 1);
        check_hold("after_reset_1c");

        wait_ce(20);
        check_drain("final_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
